pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC generator that sits directly upstream of the instruction memory fetch stage. It drives `pcNext` and a combined fetch stall, and advances only on `pulse_en`. It sequences word addresses linearly and applies branch/jump redirects, buffering one redirect that arrives while fetch is stalled or halted. It also provides a post-reset boot delay and a halt/resume mechanism for the debug controller.

## Interface
- `MEM_WORDS`, 8192: instruction memory depth in 32-bit words; power of two.
- `RESET_PC`, 0: word address fetched first after reset.
- `BOOT_PULSES`, 2: number of `pulse_en` events spent in BOOT before fetching starts; must be ≥1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `pulse_en`  in  1  single-cycle advance strobe; no state change except on cycles where it is high.
- `stall`  in  1  downstream hazard stall.
- `redirect_valid`  in  1  redirect request; sampled only when `pulse_en` is high.
- `redirect_target`  in  32  redirect word address.
- `halt_req`  in  1  enter HALT; sampled when `pulse_en` is high.
- `resume`  in  1  leave HALT; sampled when `pulse_en` is high.
- `pcNext`  out  32  registered word address presented to fetch.
- `fetch_stall`  out  1  `stall` OR (state ≠ RUN); combinational; drives the fetch stage's stall input.
- `flush`  out  1  registered; one-cycle pulse after a redirect is loaded into `pcNext`.
- `redirect_pending`  out  1  registered; the one-deep redirect buffer is occupied.
- `halted`  out  1  registered; state = HALT.

## Operation
- Address width rule: `pcNext` carries `log2(MEM_WORDS)` significant bits. Bits above those are always 0. Targets are truncated modulo `MEM_WORDS`.
- States: BOOT, RUN, HALT.
  - BOOT: `pcNext` is held at `RESET_PC`. A counter increments on each `pulse_en`. When the counter reaches `BOOT_PULSES`, the block enters RUN. Redirects and `halt_req` are ignored in BOOT.
  - RUN, advance edge: an advance is `pulse_en` & !`stall`. The new `pcNext` is chosen in this priority order:
    1. pending target; the buffer is cleared.
    2. otherwise, `redirect_target` if `redirect_valid`.
    3. otherwise, `pcNext+1`, wrapping from `MEM_WORDS-1` to 0.
    - If both a pending target and a new `redirect_valid` exist at the same advance, the pending target is applied and the new target is loaded into the buffer.
    - `flush` is set for the cycle following any edge that loads a redirect (pending or direct).
  - RUN, `pulse_en` & `stall`: `pcNext` is held. A `redirect_valid` is written into the buffer. If the buffer is already full, the newest target overwrites it.
  - RUN → HALT: on `pulse_en` & `halt_req`, stalled or not. If the same edge is an advance, that advance still completes, including any redirect.
  - HALT: `pcNext` is held and `redirect_valid` is captured into the buffer. On `pulse_en` & `resume` & !`halt_req`, the block returns to RUN. The pending target, if any, is applied at the next advance. `halt_req` wins over `resume` when both are sampled together.
- Reset (`clr` high, at any time): outputs take these values immediately:
  - state = BOOT, boot counter = 0, `pcNext` = `RESET_PC`, buffer empty, stored target = 0;
  - `flush` = 0, `redirect_pending` = 0, `halted` = 0, `fetch_stall` = 1.

## Timing
- All outputs except `fetch_stall` are registered.
- Redirect latency: a redirect sampled at an advance edge appears on `pcNext` in the next cycle. The fetch stage consumes it at the following advance.
- A redirect buffered under stall appears on `pcNext` one cycle after the first advance edge once `stall` drops.
- `flush` is high for exactly one `clk` cycle, never longer, even if `pulse_en` is low.
- Edges where `pulse_en` is low change nothing except clearing `flush`.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum {BOOT, RUN, HALT};
  - `PC_W = 32`;
  - the default `MEM_WORDS`.
- One natural sub-module, `redirect_buffer`: a one-deep valid+target register with load, overwrite and pop. The state machine and PC register stay in `pc_sequencer`.

## Test plan
- Reset and boot:
  - Stimulus: `clr`, then pulse every 4 cycles, `BOOT_PULSES`=2.
  - Response: `fetch_stall`=1 and `pcNext`=0 for 2 pulses. After that, `pcNext` counts 0→1→2 on successive pulses.
- Wrap-around:
  - Stimulus: redirect to 8191, then one more advance.
  - Response: `pcNext`=8191, then 0. `flush` pulses once, after the redirect edge only.
- Redirect under stall:
  - Stimulus: at `pcNext`=5, hold `stall`; send redirect 100, then redirect 200 on a later pulse.
  - Response: `redirect_pending`=1 and `pcNext` stays 5. After `stall` drops, `pcNext`=200 with `flush`. The buffer is empty afterwards.
- Halt/resume with a redirect during HALT:
  - Stimulus: `halt_req` at `pcNext`=10, redirect 40 while halted, then `resume`.
  - Response: `halted`=1 and `fetch_stall`=1 while halted, with `pcNext`=10. After resume, the next advance gives `pcNext`=40.
- Simultaneous events:
  - Stimulus: `halt_req`+`resume` together in HALT.
  - Response: the block stays halted.
  - Stimulus: `halt_req`+`redirect_valid` at an advance in RUN.
  - Response: `pcNext`=target, `flush`=1, `halted`=1.
- Mid-operation reset:
  - Stimulus: assert `clr` between clock edges while the buffer is full and the block is in RUN.
  - Response: the outputs immediately take their reset values, with no clock edge required.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch front end.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

  localparam int PC_W              = 32;
  localparam int MEM_WORDS_DEFAULT = 8192;

endpackage

// File: rtl/redirect_buffer.sv
// One-deep redirect target holder; a load in the same cycle as a pop keeps the
// entry occupied with the newer target.
module redirect_buffer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         pop,
  input  logic [W-1:0] target_in,
  output logic         valid,
  output logic [W-1:0] target
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      target <= target_in;
    end else if (pop) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generator: boot delay, linear word sequencing, redirects with a
// one-deep buffer for redirects arriving under stall or halt, and debug halt.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS   = MEM_WORDS_DEFAULT,
  parameter int RESET_PC    = 0,
  parameter int BOOT_PULSES = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            pulse_en,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] pcNext,
  output logic            fetch_stall,
  output logic            flush,
  output logic            redirect_pending,
  output logic            halted
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(BOOT_PULSES + 1);

  seq_state_e    state;
  logic [CW-1:0] boot_cnt;
  logic [AW-1:0] pc;
  logic          buf_valid;
  logic [AW-1:0] buf_target;
  logic          buf_load;
  logic          buf_pop;
  logic          advance;
  logic          unused_target_hi;

  // Targets are taken modulo the memory depth, so the high bits are dropped.
  assign unused_target_hi = ^redirect_target[PC_W-1:AW];

  assign advance = pulse_en && !stall && (state == RUN);
  assign buf_pop = advance && buf_valid;
  // A redirect is parked when it cannot be applied directly this edge:
  // stalled, halted, or queued behind an already pending target.
  assign buf_load = pulse_en && redirect_valid &&
                    (((state == RUN) && (stall || buf_valid)) || (state == HALT));

  redirect_buffer #(.W(AW)) u_redirect_buffer (
    .clk       (clk),
    .clr       (clr),
    .load      (buf_load),
    .pop       (buf_pop),
    .target_in (redirect_target[AW-1:0]),
    .valid     (buf_valid),
    .target    (buf_target)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= BOOT;
      boot_cnt <= '0;
      pc       <= AW'(RESET_PC);
      flush    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      flush <= 1'b0;
      if (pulse_en) begin
        case (state)
          BOOT: begin
            boot_cnt <= boot_cnt + CW'(1);
            if (boot_cnt == CW'(BOOT_PULSES - 1)) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (!stall) begin
              if (buf_valid) begin
                pc    <= buf_target;
                flush <= 1'b1;
              end else if (redirect_valid) begin
                pc    <= redirect_target[AW-1:0];
                flush <= 1'b1;
              end else begin
                pc <= pc + AW'(1);
              end
            end
            if (halt_req) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
          HALT: begin
            if (resume && !halt_req) begin
              state  <= RUN;
              halted <= 1'b0;
            end
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

  assign pcNext           = {{(PC_W - AW){1'b0}}, pc};
  assign redirect_pending = buf_valid;
  assign fetch_stall      = stall || (state != RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_pc_sequencer;

  localparam int MEM_WORDS   = 8192;
  localparam int RESET_PC    = 0;
  localparam int BOOT_PULSES = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        pulse_en;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pcNext;
  logic        fetch_stall;
  logic        flush;
  logic        redirect_pending;
  logic        halted;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit started   = 1'b0;

  // Model state: mode 0 = boot, 1 = run, 2 = halt.
  int          m_mode   = 0;
  int          m_boot   = 0;
  int unsigned m_pc     = RESET_PC;
  bit          m_pend   = 1'b0;
  int unsigned m_pend_t = 0;
  bit          m_flush  = 1'b0;

  pc_sequencer #(
    .MEM_WORDS   (MEM_WORDS),
    .RESET_PC    (RESET_PC),
    .BOOT_PULSES (BOOT_PULSES)
  ) dut (
    .clk              (clk),
    .clr              (clr),
    .pulse_en         (pulse_en),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .halt_req         (halt_req),
    .resume           (resume),
    .pcNext           (pcNext),
    .fetch_stall      (fetch_stall),
    .flush            (flush),
    .redirect_pending (redirect_pending),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model driven from the sampled inputs at each rising edge.
  initial begin
    forever begin
      @(posedge clk or posedge clr);
      if (clr) begin
        m_mode = 0; m_boot = 0; m_pc = RESET_PC; m_pend = 0; m_pend_t = 0; m_flush = 0;
      end else begin
        m_flush = 0;
        if (pulse_en) begin
          if (m_mode == 0) begin
            m_boot++;
            if (m_boot == BOOT_PULSES) m_mode = 1;
          end else if (m_mode == 1) begin
            if (!stall) begin
              if (m_pend) begin
                m_pc = m_pend_t;
                m_flush = 1;
                m_pend = redirect_valid;
                if (redirect_valid) m_pend_t = redirect_target % MEM_WORDS;
              end else if (redirect_valid) begin
                m_pc = redirect_target % MEM_WORDS;
                m_flush = 1;
              end else begin
                m_pc = (m_pc + 1) % MEM_WORDS;
              end
            end else if (redirect_valid) begin
              m_pend = 1;
              m_pend_t = redirect_target % MEM_WORDS;
            end
            if (halt_req) m_mode = 2;
          end else begin
            if (redirect_valid) begin
              m_pend = 1;
              m_pend_t = redirect_target % MEM_WORDS;
            end
            if (resume && !halt_req) m_mode = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("cyc pcNext", pcNext, m_pc);
        chk("cyc fetch_stall", {31'd0, fetch_stall}, {31'd0, stall | (m_mode != 1)});
        chk("cyc flush", {31'd0, flush}, {31'd0, m_flush});
        chk("cyc redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
        chk("cyc halted", {31'd0, halted}, {31'd0, m_mode == 2});
      end
    end
  end

  // Called at posedge+2; leaves inputs changed just after the pulse edge.
  task automatic step(input logic rv, input logic [31:0] tgt, input logic hr, input logic rs);
    pulse_en = 1'b1; redirect_valid = rv; redirect_target = tgt; halt_req = hr; resume = rs;
    @(posedge clk); #2;
    pulse_en = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    $display("step rv=%0d tgt=%0d halt=%0d resume=%0d stall=%0d -> pcNext=%0d flush=%0d pend=%0d halted=%0d",
             rv, tgt, hr, rs, stall, pcNext, flush, redirect_pending, halted);
  endtask

  // Non-pulse cycles carry random redirect/halt noise that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      redirect_valid  = 1'($urandom_range(0, 1));
      redirect_target = $urandom;
      halt_req        = 1'($urandom_range(0, 1));
      resume          = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
    redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  initial begin
    clr = 1'b1; pulse_en = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; halt_req = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk); #2;
    chk("reset pcNext", pcNext, 32'd0);
    chk("reset fetch_stall", {31'd0, fetch_stall}, 32'd1);
    chk("reset halted", {31'd0, halted}, 32'd0);
    started = 1'b1;
    clr = 1'b0;
    idle(2);

    // Boot: redirect and halt requests must be ignored.
    step(1'b1, 32'd77, 1'b1, 1'b0);
    chk("boot1 fetch_stall", {31'd0, fetch_stall}, 32'd1);
    chk("boot1 pending", {31'd0, redirect_pending}, 32'd0);
    chk("boot1 halted", {31'd0, halted}, 32'd0);
    idle(3);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("boot2 fetch_stall", {31'd0, fetch_stall}, 32'd0);
    chk("boot2 pcNext", pcNext, 32'd0);
    idle(3);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("run pc1", pcNext, 32'd1);
    idle(3);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("run pc2", pcNext, 32'd2);
    idle(3);

    // Wrap-around.
    step(1'b1, 32'd8191, 1'b0, 1'b0);
    chk("wrap redirect pc", pcNext, 32'd8191);
    chk("wrap flush", {31'd0, flush}, 32'd1);
    idle(1);
    chk("wrap flush clears", {31'd0, flush}, 32'd0);
    idle(2);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("wrap to zero", pcNext, 32'd0);
    chk("wrap no flush", {31'd0, flush}, 32'd0);
    idle(3);

    // Target truncation: 0x12005 mod 8192 = 5.
    step(1'b1, 32'h0001_2005, 1'b0, 1'b0);
    chk("truncate pc", pcNext, 32'd5);
    idle(3);

    // Redirects under stall: newest wins.
    stall = 1'b1;
    step(1'b1, 32'd100, 1'b0, 1'b0);
    chk("stall pending", {31'd0, redirect_pending}, 32'd1);
    chk("stall hold pc", pcNext, 32'd5);
    idle(3);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 32'd200, 1'b0, 1'b0);
    chk("stall hold pc2", pcNext, 32'd5);
    stall = 1'b0;
    idle(3);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("unstall pc", pcNext, 32'd200);
    chk("unstall flush", {31'd0, flush}, 32'd1);
    chk("unstall pending", {31'd0, redirect_pending}, 32'd0);
    idle(3);

    // Halt at pcNext=10 with a redirect captured while halted.
    step(1'b1, 32'd10, 1'b0, 1'b0);
    idle(3);
    stall = 1'b1;
    step(1'b0, 32'd0, 1'b1, 1'b0);
    stall = 1'b0;
    chk("halt halted", {31'd0, halted}, 32'd1);
    chk("halt fetch_stall", {31'd0, fetch_stall}, 32'd1);
    chk("halt pc", pcNext, 32'd10);
    idle(3);
    step(1'b1, 32'd40, 1'b0, 1'b0);
    chk("halt pending", {31'd0, redirect_pending}, 32'd1);
    chk("halt pc hold", pcNext, 32'd10);
    idle(3);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("halt wins resume", {31'd0, halted}, 32'd1);
    idle(3);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("resume halted", {31'd0, halted}, 32'd0);
    chk("resume pc hold", pcNext, 32'd10);
    idle(3);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("resume apply pc", pcNext, 32'd40);
    chk("resume flush", {31'd0, flush}, 32'd1);
    idle(3);

    // Pending target applied while a new redirect refills the buffer.
    stall = 1'b1;
    step(1'b1, 32'd300, 1'b0, 1'b0);
    stall = 1'b0;
    idle(1);
    step(1'b1, 32'd400, 1'b0, 1'b0);
    chk("dual pc", pcNext, 32'd300);
    chk("dual pending", {31'd0, redirect_pending}, 32'd1);
    idle(1);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("dual second pc", pcNext, 32'd400);
    chk("dual drained", {31'd0, redirect_pending}, 32'd0);
    idle(3);

    // halt_req together with a redirect at an advance.
    step(1'b1, 32'd555, 1'b1, 1'b0);
    chk("halt+redir pc", pcNext, 32'd555);
    chk("halt+redir flush", {31'd0, flush}, 32'd1);
    chk("halt+redir halted", {31'd0, halted}, 32'd1);
    idle(2);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    idle(2);

    // Asynchronous reset mid-operation with the buffer full.
    stall = 1'b1;
    step(1'b1, 32'd777, 1'b0, 1'b0);
    chk("pre-reset pending", {31'd0, redirect_pending}, 32'd1);
    idle(1);
    clr = 1'b1;
    #1;
    chk("async pcNext", pcNext, 32'd0);
    chk("async pending", {31'd0, redirect_pending}, 32'd0);
    chk("async flush", {31'd0, flush}, 32'd0);
    chk("async halted", {31'd0, halted}, 32'd0);
    chk("async fetch_stall", {31'd0, fetch_stall}, 32'd1);
    stall = 1'b0;
    @(posedge clk); #2;
    clr = 1'b0;
    idle(1);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("reboot stall", {31'd0, fetch_stall}, 32'd1);
    idle(1);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("reboot run", {31'd0, fetch_stall}, 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("reboot pc1", pcNext, 32'd1);
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
